udma_traffic_gen_mc: RTL and testbench

// Multi-channel, width-parametrised traffic generator/checker behind the uDMA external-peripheral data_tx_dc/data_rx_dc streams.

---
 rtl/udma_traffic_gen_pkg.sv | 37 +++
 rtl/udma_traffic_gen_ch.sv | 215 +++++++++++++++++++++
 rtl/udma_traffic_gen_mc.sv | 54 +++++
 tb/tb_udma_traffic_gen_mc.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_traffic_gen_pkg.sv
// Shared definitions for the uDMA traffic generator/checker.
// Holds the channel mode and FSM state encodings, the bit layout of the
// 32-bit per-channel setup word and the LFSR constants plus its step function.
package udma_traffic_gen_pkg;

  typedef enum logic [1:0] {
    MODE_SINK = 2'd0,
    MODE_CNT  = 2'd1,
    MODE_LOOP = 2'd2,
    MODE_LFSR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Setup word layout
  localparam int MODE_LSB   = 0;
  localparam int MODE_W     = 2;
  localparam int EN_BIT     = 2;
  localparam int THR_LSB    = 8;
  localparam int THR_W      = 8;
  localparam int NBEATS_LSB = 16;
  localparam int NBEATS_W   = 16;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

  // Right-shifting Galois LFSR: feedback taps are XORed in when bit 0 falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/udma_traffic_gen_ch.sv
// One traffic generator/checker channel.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cfg_setup_i[31:0]       setup word (mode, en, thr, nbeats)
//   tx_data_i/valid/ready   uDMA -> generator stream
//   rx_data_o/valid/ready   generator -> uDMA stream
//   busy_o                  channel in RUN or WAIT
//   done_o                  one-cycle pulse on reaching nbeats
//   beat_cnt_o              accepted beats since start (saturating)
//   chksum_o                XOR of accepted TX beats since start
module udma_traffic_gen_ch
  import udma_traffic_gen_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cfg_setup_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       beat_cnt_o,
  output logic [DATA_W-1:0] chksum_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    PTR_ONE = (PTR_W + 1)'(1);
  localparam logic [DATA_W-1:0] CTR_ONE = DATA_W'(1);

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [THR_W-1:0]      thr_q, thr_d, wait_q, wait_d;
  logic [NBEATS_W-1:0]   nbeats_q, nbeats_d, cnt_q, cnt_d;
  logic [DATA_W-1:0]     chksum_q, chksum_d, ctr_q, ctr_d;
  logic [31:0]           lfsr_q, lfsr_d;
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]     mem_d [FIFO_DEPTH];
  logic                  done_q, done_d;

  mode_e                 cfg_mode;
  logic                  cfg_en;
  logic [THR_W-1:0]      cfg_thr;
  logic [NBEATS_W-1:0]   cfg_nbeats;
  logic [4:0]            unused_cfg_bits;

  assign cfg_mode        = mode_e'(cfg_setup_i[MODE_LSB +: MODE_W]);
  assign cfg_en          = cfg_setup_i[EN_BIT];
  assign cfg_thr         = cfg_setup_i[THR_LSB +: THR_W];
  assign cfg_nbeats      = cfg_setup_i[NBEATS_LSB +: NBEATS_W];
  assign unused_cfg_bits = cfg_setup_i[7:3];

  logic fifo_empty, fifo_full;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  logic              tx_ready, rx_valid, tx_acc, rx_acc, beat;
  logic [DATA_W-1:0] rx_data;

  // tx_ready is gated by the live enable so a disabled channel takes no new
  // input while it drains its pending RX beat; rx_valid never depends on en,
  // so an offered beat is never withdrawn.
  always_comb begin
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    case (mode_q)
      MODE_SINK: tx_ready = cfg_en && (state_q == ST_RUN);
      MODE_CNT: begin
        rx_valid = (state_q == ST_RUN);
        rx_data  = ctr_q;
      end
      MODE_LOOP: begin
        tx_ready = cfg_en && !fifo_full && (state_q == ST_RUN || state_q == ST_WAIT);
        rx_valid = (state_q == ST_RUN) && !fifo_empty;
        rx_data  = mem_q[rd_ptr_q[PTR_W-1:0]];
      end
      default: begin
        rx_valid = (state_q == ST_RUN);
        rx_data  = lfsr_q[DATA_W-1:0];
      end
    endcase
    if (!rx_valid) rx_data = '0;
  end

  assign tx_acc = tx_valid_i && tx_ready;
  assign rx_acc = rx_valid && rx_ready_i;
  assign beat   = (mode_q == MODE_SINK) ? tx_acc : rx_acc;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    thr_d    = thr_q;
    nbeats_d = nbeats_q;
    wait_d   = wait_q;
    cnt_d    = cnt_q;
    chksum_d = chksum_q;
    ctr_d    = ctr_q;
    lfsr_d   = lfsr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    done_d   = 1'b0;

    if (tx_acc) begin
      chksum_d = chksum_q ^ tx_data_i;
      if (mode_q == MODE_LOOP) begin
        mem_d[wr_ptr_q[PTR_W-1:0]] = tx_data_i;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
    end

    if (beat) begin
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      case (mode_q)
        MODE_CNT:  ctr_d    = ctr_q + CTR_ONE;
        MODE_LFSR: lfsr_d   = lfsr_next(lfsr_q);
        MODE_LOOP: rd_ptr_d = rd_ptr_q + PTR_ONE;
        default:   ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        // FIFO is held empty while idle, which also flushes it after a disable.
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        if (cfg_en) begin
          state_d  = ST_RUN;
          mode_d   = cfg_mode;
          thr_d    = cfg_thr;
          nbeats_d = cfg_nbeats;
          cnt_d    = '0;
          chksum_d = '0;
          ctr_d    = '0;
          lfsr_d   = LFSR_SEED;
        end
      end
      ST_RUN: begin
        if (beat) begin
          if (nbeats_q != '0 && (cnt_q + 16'd1) == nbeats_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (!cfg_en) begin
            state_d = ST_IDLE;
          end else if (thr_q != '0) begin
            state_d = ST_WAIT;
            wait_d  = thr_q;
          end
        end else if (!cfg_en && !rx_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!cfg_en)                state_d = ST_IDLE;
        else if (wait_q == 8'd1)    state_d = ST_RUN;
        else                        wait_d  = wait_q - 8'd1;
      end
      default: begin
        if (!cfg_en) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_SINK;
      thr_q    <= '0;
      nbeats_q <= '0;
      wait_q   <= '0;
      cnt_q    <= '0;
      chksum_q <= '0;
      ctr_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      thr_q    <= thr_d;
      nbeats_q <= nbeats_d;
      wait_q   <= wait_d;
      cnt_q    <= cnt_d;
      chksum_q <= chksum_d;
      ctr_q    <= ctr_d;
      lfsr_q   <= lfsr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      done_q   <= done_d;
    end
  end

  // FIFO storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign tx_ready_o = tx_ready;
  assign rx_valid_o = rx_valid;
  assign rx_data_o  = rx_data;
  assign busy_o     = (state_q == ST_RUN) || (state_q == ST_WAIT);
  assign done_o     = done_q;
  assign beat_cnt_o = cnt_q;
  assign chksum_o   = chksum_q;

endmodule

// File: rtl/udma_traffic_gen_mc.sv
// Multi-channel uDMA traffic generator/checker: NUM_CH independent channels
// behind the data_tx_dc / data_rx_dc streams. Slicing and wiring only.
// Ports (channel n occupies slice n of every bus):
//   clk_i, rst_i       clock, synchronous active-high reset
//   cfg_setup_i        NUM_CH x 32 setup words
//   tx_*               uDMA -> generator streams
//   rx_*               generator -> uDMA streams
//   busy_o, done_o     per-channel status
//   beat_cnt_o         NUM_CH x 16 accepted beat counters
//   chksum_o           NUM_CH x DATA_W XOR checksums of accepted TX beats
module udma_traffic_gen_mc
  import udma_traffic_gen_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH*32-1:0]     cfg_setup_i,
  input  logic [NUM_CH*DATA_W-1:0] tx_data_i,
  input  logic [NUM_CH-1:0]        tx_valid_i,
  output logic [NUM_CH-1:0]        tx_ready_o,
  output logic [NUM_CH*DATA_W-1:0] rx_data_o,
  output logic [NUM_CH-1:0]        rx_valid_o,
  input  logic [NUM_CH-1:0]        rx_ready_i,
  output logic [NUM_CH-1:0]        busy_o,
  output logic [NUM_CH-1:0]        done_o,
  output logic [NUM_CH*16-1:0]     beat_cnt_o,
  output logic [NUM_CH*DATA_W-1:0] chksum_o
);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    udma_traffic_gen_ch #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cfg_setup_i (cfg_setup_i[32*n +: 32]),
      .tx_data_i   (tx_data_i[DATA_W*n +: DATA_W]),
      .tx_valid_i  (tx_valid_i[n]),
      .tx_ready_o  (tx_ready_o[n]),
      .rx_data_o   (rx_data_o[DATA_W*n +: DATA_W]),
      .rx_valid_o  (rx_valid_o[n]),
      .rx_ready_i  (rx_ready_i[n]),
      .busy_o      (busy_o[n]),
      .done_o      (done_o[n]),
      .beat_cnt_o  (beat_cnt_o[16*n +: 16]),
      .chksum_o    (chksum_o[DATA_W*n +: DATA_W])
    );
  end

endmodule

// File: tb/tb_udma_traffic_gen_mc.sv
// Bench for udma_traffic_gen_mc: a behavioural per-channel model (queues and
// integer counters) checked against every output on every falling edge, plus
// directed scenarios with hand-computed literal expectations.
module tb_udma_traffic_gen_mc;

  localparam int NCH   = 4;
  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic              clk;
  logic              rst;
  logic [NCH*32-1:0] cfg_setup;
  logic [NCH*W-1:0]  tx_data;
  logic [NCH-1:0]    tx_valid;
  logic [NCH-1:0]    tx_ready;
  logic [NCH*W-1:0]  rx_data;
  logic [NCH-1:0]    rx_valid;
  logic [NCH-1:0]    rx_ready;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done;
  logic [NCH*16-1:0] beat_cnt;
  logic [NCH*W-1:0]  chksum;

  udma_traffic_gen_mc #(.NUM_CH(NCH), .DATA_W(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_setup_i (cfg_setup),
    .tx_data_i   (tx_data),
    .tx_valid_i  (tx_valid),
    .tx_ready_o  (tx_ready),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .busy_o      (busy),
    .done_o      (done),
    .beat_cnt_o  (beat_cnt),
    .chksum_o    (chksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input int c, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s ch%0d: got 0x%0h expected 0x%0h (t=%0t)", nm, c, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          model_live = 1'b0;
  bit          m_active [NCH];   // RUN or in an idle gap
  bit          m_fin    [NCH];   // reached nbeats, waiting for en=0
  bit          m_done   [NCH];
  int          m_gap    [NCH];   // idle cycles still to serve
  int          m_mode   [NCH];
  int          m_thr    [NCH];
  int          m_nb     [NCH];
  int          m_beats  [NCH];
  logic [31:0] m_xsum   [NCH];
  logic [31:0] m_ctr    [NCH];
  logic [31:0] m_lfsr   [NCH];
  logic [31:0] m_q      [NCH][$];

  function automatic void model_outs(input int c, output bit tr, output bit rv, output logic [31:0] rd);
    bit en;
    bit run;
    en  = cfg_setup[32*c + 2];
    run = m_active[c] && (m_gap[c] == 0);
    tr  = 1'b0;
    rv  = 1'b0;
    rd  = '0;
    case (m_mode[c])
      0: tr = run && en;
      1: rv = run;
      2: begin
        tr = m_active[c] && en && (m_q[c].size() < DEPTH);
        rv = run && (m_q[c].size() > 0);
      end
      default: rv = run;
    endcase
    if (rv) begin
      if (m_mode[c] == 1)      rd = m_ctr[c];
      else if (m_mode[c] == 3) rd = m_lfsr[c];
      else                     rd = m_q[c][0];
    end
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      logic [31:0] cw, rd, din;
      bit en, tr, rv, txa, rxa, bt;
      cw  = cfg_setup[32*c +: 32];
      en  = cw[2];
      din = tx_data[W*c +: W];
      model_outs(c, tr, rv, rd);
      m_done[c] = 1'b0;
      if (rst) begin
        m_active[c] = 0; m_fin[c] = 0; m_gap[c] = 0; m_mode[c] = 0;
        m_beats[c] = 0; m_xsum[c] = '0; m_ctr[c] = '0; m_lfsr[c] = SEED;
        m_q[c].delete();
      end else if (!m_active[c]) begin
        if (m_fin[c]) begin
          if (!en) begin m_fin[c] = 0; m_q[c].delete(); end
        end else if (en) begin
          m_mode[c] = int'(cw[1:0]); m_thr[c] = int'(cw[15:8]); m_nb[c] = int'(cw[31:16]);
          m_beats[c] = 0; m_xsum[c] = '0; m_ctr[c] = '0; m_lfsr[c] = SEED;
          m_gap[c] = 0; m_q[c].delete(); m_active[c] = 1;
        end else begin
          m_q[c].delete();
        end
      end else begin
        txa = tx_valid[c] && tr;
        rxa = rv && rx_ready[c];
        bt  = (m_mode[c] == 0) ? txa : rxa;
        if (txa) m_xsum[c] = m_xsum[c] ^ din;
        if (bt) begin
          m_beats[c]++;
          m_ctr[c]  = m_ctr[c] + 32'd1;
          m_lfsr[c] = {1'b0, m_lfsr[c][31:1]} ^ (m_lfsr[c][0] ? POLY : 32'h0);
          if (m_mode[c] == 2) void'(m_q[c].pop_front());
        end
        if (txa && m_mode[c] == 2) m_q[c].push_back(din);
        if (m_gap[c] > 0) begin
          if (!en) begin m_active[c] = 0; m_gap[c] = 0; m_q[c].delete(); end
          else m_gap[c]--;
        end else if (bt) begin
          if (m_nb[c] != 0 && m_beats[c] == m_nb[c]) begin
            m_active[c] = 0; m_fin[c] = 1; m_done[c] = 1;
          end else if (!en) begin
            m_active[c] = 0; m_q[c].delete();
          end else begin
            m_gap[c] = m_thr[c];
          end
        end else if (!en && !rv) begin
          m_active[c] = 0; m_q[c].delete();
        end
      end
    end
    model_live = 1'b1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      for (int c = 0; c < NCH; c++) begin
        bit tr, rv;
        logic [31:0] rd;
        int bc;
        model_outs(c, tr, rv, rd);
        bc = (m_beats[c] > 65535) ? 65535 : m_beats[c];
        check("tx_ready", c, tx_ready[c], tr);
        check("rx_valid", c, rx_valid[c], rv);
        check("rx_data",  c, rx_data[W*c +: W], rd);
        check("busy",     c, busy[c], m_active[c]);
        check("done",     c, done[c], m_done[c]);
        check("beat_cnt", c, beat_cnt[16*c +: 16], bc[15:0]);
        check("chksum",   c, chksum[W*c +: W], m_xsum[c]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_cfg(input int c, input logic [1:0] mode, input logic en,
                         input logic [7:0] thr, input logic [15:0] nb);
    cfg_setup[32*c +: 32] = {nb, thr, 5'd0, en, mode};
  endtask

  task automatic set_tx(input int c, input logic v, input logic [31:0] d);
    tx_valid[c]        = v;
    tx_data[W*c +: W]  = d;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int          hits[$];
    bit          seen;
    logic [31:0] d0;
    logic [3:0]  rdy_pat;
    logic [31:0] cnt_exp [4];

    rst = 1'b1; cfg_setup = '0; tx_data = '0; tx_valid = '0; rx_ready = '0;
    tick(); tick(); settle();
    check("rst_tx_ready", 0, tx_ready, 0);
    check("rst_rx_valid", 0, rx_valid, 0);
    check("rst_rx_data",  0, rx_data, 0);
    check("rst_busy",     0, busy, 0);
    check("rst_beat_cnt", 0, beat_cnt, 0);
    check("rst_chksum",   0, chksum, 0);
    rst = 1'b0;
    tick();

    // SINK ch0: 4 beats back-to-back, checksum 1^2^4^8
    set_cfg(0, 2'd0, 1'b1, 8'd0, 16'd4);
    tick(); settle();
    check("sink_busy", 0, busy[0], 1);
    for (int i = 0; i < 4; i++) begin
      set_tx(0, 1'b1, 32'd1 << i);
      settle();
      check("sink_ready", 0, tx_ready[0], 1);
      tick();
    end
    set_tx(0, 1'b0, 32'd0);
    settle();
    check("sink_done",   0, done[0], 1);
    check("sink_busy0",  0, busy[0], 0);
    check("sink_chksum", 0, chksum[31:0], 32'hF);
    check("sink_beats",  0, beat_cnt[15:0], 16'd4);
    tick(); settle();
    check("sink_done_pulse", 0, done[0], 0);
    set_cfg(0, 2'd0, 1'b0, 8'd0, 16'd4);
    tick();

    // CNT ch1: ready pattern 1,0,1,1 -> data 0,1,1,2
    rdy_pat = 4'b1101;
    cnt_exp[0] = 0; cnt_exp[1] = 1; cnt_exp[2] = 1; cnt_exp[3] = 2;
    set_cfg(1, 2'd1, 1'b1, 8'd0, 16'd3);
    tick();
    for (int i = 0; i < 4; i++) begin
      rx_ready[1] = rdy_pat[i];
      settle();
      check("cnt_valid", 1, rx_valid[1], 1);
      check("cnt_data",  1, rx_data[W*1 +: W], cnt_exp[i]);
      tick();
    end
    settle();
    check("cnt_done",  1, done[1], 1);
    check("cnt_busy",  1, busy[1], 0);
    check("cnt_beats", 1, beat_cnt[16*1 +: 16], 16'd3);
    set_cfg(1, 2'd1, 1'b0, 8'd0, 16'd3);
    rx_ready[1] = 1'b0;
    tick();

    // LFSR ch2: two beats, then restart gives the same sequence
    rx_ready[2] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      set_cfg(2, 2'd3, 1'b1, 8'd0, 16'd2);
      tick(); settle();
      check("lfsr_first", 2, rx_data[W*2 +: W], 32'hACE1_0001);
      tick(); settle();
      check("lfsr_second", 2, rx_data[W*2 +: W], 32'hD650_8003);
      tick(); settle();
      check("lfsr_done", 2, done[2], 1);
      set_cfg(2, 2'd3, 1'b0, 8'd0, 16'd2);
      tick();
    end
    rx_ready[2] = 1'b0;

    // LOOP ch3: fill 8, 9th blocked, then drain with concurrent push/pop
    set_cfg(3, 2'd2, 1'b1, 8'd0, 16'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      set_tx(3, 1'b1, 32'h100 + i);
      settle();
      check("loop_fill_ready", 3, tx_ready[3], 1);
      tick();
    end
    set_tx(3, 1'b1, 32'h108);
    settle();
    check("loop_full_ready", 3, tx_ready[3], 0);
    check("loop_head",       3, rx_data[W*3 +: W], 32'h100);
    tick();
    rx_ready[3] = 1'b1;
    settle();
    check("loop_full_ready2", 3, tx_ready[3], 0);
    tick();
    for (int k = 0; k < 6; k++) begin
      set_tx(3, 1'b1, 32'h108 + k);
      settle();
      check("loop_pp_ready", 3, tx_ready[3], 1);
      check("loop_pp_data",  3, rx_data[W*3 +: W], 32'h101 + k);
      tick();
    end
    set_tx(3, 1'b0, 32'd0);
    for (int m = 0; m < 7; m++) begin
      settle();
      check("loop_drain_valid", 3, rx_valid[3], 1);
      check("loop_drain_data",  3, rx_data[W*3 +: W], 32'h107 + m);
      tick();
    end
    settle();
    check("loop_empty",  3, rx_valid[3], 0);
    check("loop_chksum", 3, chksum[W*3 +: W], 32'h1);
    check("loop_beats",  3, beat_cnt[16*3 +: 16], 16'd14);
    rx_ready[3] = 1'b0;
    set_cfg(3, 2'd2, 1'b0, 8'd0, 16'd0);
    tick();

    // Throttle: CNT thr=3 -> accepted beats 4 cycles apart
    rx_ready[1] = 1'b1;
    set_cfg(1, 2'd1, 1'b1, 8'd3, 16'd0);
    tick();
    for (int cyc = 0; cyc < 16; cyc++) begin
      settle();
      if (rx_valid[1]) hits.push_back(cyc);
      tick();
    end
    check("thr_hits", 1, hits.size(), 4);
    if (hits.size() >= 3) begin
      check("thr_gap0", 1, hits[1] - hits[0] - 1, 3);
      check("thr_gap1", 1, hits[2] - hits[1] - 1, 3);
    end

    // en cleared while a beat is stalled: valid holds until taken
    rx_ready[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      settle();
      if (rx_valid[1]) seen = 1'b1;
      else tick();
    end
    check("encl_wait_valid", 1, seen, 1);
    cfg_setup[32*1 + 2] = 1'b0;
    d0 = rx_data[W*1 +: W];
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check("encl_hold_valid", 1, rx_valid[1], 1);
      check("encl_hold_data",  1, rx_data[W*1 +: W], d0);
    end
    rx_ready[1] = 1'b1;
    tick(); settle();
    check("encl_idle_busy",  1, busy[1], 0);
    check("encl_idle_valid", 1, rx_valid[1], 0);
    rx_ready[1] = 1'b0;
    tick();

    // Reset mid-run on all channels
    set_cfg(0, 2'd0, 1'b1, 8'd0, 16'd0);
    set_cfg(1, 2'd1, 1'b1, 8'd0, 16'd0);
    set_cfg(2, 2'd3, 1'b1, 8'd0, 16'd0);
    set_cfg(3, 2'd2, 1'b1, 8'd0, 16'd0);
    rx_ready = '1;
    set_tx(0, 1'b1, 32'h55);
    set_tx(3, 1'b1, 32'hAA);
    repeat (4) tick();
    settle();
    check("pre_rst_busy", 0, busy, 4'hF);
    rst = 1'b1;
    tick(); settle();
    check("mid_rst_tx_ready", 0, tx_ready, 0);
    check("mid_rst_rx_valid", 0, rx_valid, 0);
    check("mid_rst_rx_data",  0, rx_data, 0);
    check("mid_rst_busy",     0, busy, 0);
    check("mid_rst_done",     0, done, 0);
    check("mid_rst_beat_cnt", 0, beat_cnt, 0);
    check("mid_rst_chksum",   0, chksum, 0);
    cfg_setup = '0; tx_valid = '0; rx_ready = '0;
    rst = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
